// File: rtl/bnn_xnor_neuron_array.sv
// Binary fully-connected layer: XNOR-popcount of a streamed activation vector
// against per-neuron weights, thresholded into one output bit per neuron.
module bnn_xnor_neuron_array #(
    parameter int IN_BITS = 16,
    parameter int CHUNK   = 4,
    parameter int NEURONS = 4,
    parameter int ACC_W   = $clog2(IN_BITS + 1),
    parameter int TH_RST  = IN_BITS / 2,
    localparam int BEATS  = IN_BITS / CHUNK,
    localparam int NW     = (NEURONS > 1) ? $clog2(NEURONS) : 1,
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wt_we,
    input  logic [NW-1:0]      wt_neuron,
    input  logic [BW-1:0]      wt_beat,
    input  logic [CHUNK-1:0]   wt_data,
    input  logic               th_we,
    input  logic [ACC_W-1:0]   th_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NEURONS-1:0] out_data,
    output logic               busy
);

    typedef enum logic {ST_ACCUM, ST_EMIT} state_t;

    state_t             state_reg, state_next;
    logic [BW-1:0]      beat_cnt_reg;
    logic [NEURONS-1:0] out_data_reg;
    logic [NEURONS-1:0] fire;
    logic               accept;
    logic               last_beat;
    logic               release_out;

    function automatic logic [ACC_W-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [ACC_W-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + ACC_W'(v[i]);
        end
        return c;
    endfunction

    assign last_beat   = (beat_cnt_reg == BW'(BEATS - 1));
    assign accept      = in_valid && in_ready;
    assign release_out = out_valid && out_ready;
    assign busy        = (beat_cnt_reg != '0) || (state_reg == ST_EMIT);
    assign out_data    = out_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_ACCUM;
                end
            end
            default: state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= '0;
        end else if (accept) begin
            beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg <= '0;
        end else if (accept && last_beat) begin
            out_data_reg <= fire;
        end
    end

    for (genvar gi = 0; gi < NEURONS; gi++) begin : g_neuron
        logic [CHUNK-1:0] weight_reg [BEATS];
        logic [ACC_W-1:0] th_reg;
        logic [ACC_W-1:0] acc_reg;
        logic [ACC_W-1:0] acc_next;
        logic             sel;

        // Writes land after this cycle's beat, so a same-cycle beat sees the old weight.
        assign sel      = (wt_neuron == NW'(gi));
        assign acc_next = acc_reg + popcount(~(in_data ^ weight_reg[beat_cnt_reg]));
        assign fire[gi] = (acc_next >= th_reg);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int b = 0; b < BEATS; b++) begin
                    weight_reg[b] <= '0;
                end
            end else if (wt_we && sel) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (wt_beat == BW'(b)) begin
                        weight_reg[b] <= wt_data;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                th_reg <= ACC_W'(TH_RST);
            end else if (th_we && sel) begin
                th_reg <= th_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_reg <= '0;
            end else if (accept) begin
                acc_reg <= acc_next;
            end else if (release_out) begin
                acc_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bnn_xnor_neuron_array.sv
// Bench for bnn_xnor_neuron_array: transaction-level reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_bnn_xnor_neuron_array;

    localparam int IN_BITS = 16;
    localparam int CHUNK   = 4;
    localparam int NEURONS = 4;
    localparam int ACC_W   = 5;
    localparam int BEATS   = IN_BITS / CHUNK;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wt_we = 1'b0;
    logic [1:0]         wt_neuron = '0;
    logic [1:0]         wt_beat = '0;
    logic [CHUNK-1:0]   wt_data = '0;
    logic               th_we = 1'b0;
    logic [ACC_W-1:0]   th_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [CHUNK-1:0]   in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [NEURONS-1:0] out_data;
    logic               busy;

    int n_cmp = 0;
    int n_bad = 0;

    bnn_xnor_neuron_array #(
        .IN_BITS(IN_BITS), .CHUNK(CHUNK), .NEURONS(NEURONS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wt_we(wt_we), .wt_neuron(wt_neuron), .wt_beat(wt_beat), .wt_data(wt_data),
        .th_we(th_we), .th_data(th_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: counts matching bits per neuron beat by beat
    int                 m_beat;
    bit                 m_emit;
    logic [NEURONS-1:0] m_out;
    int                 m_acc [NEURONS];
    logic [IN_BITS-1:0] m_w   [NEURONS];
    int                 m_th  [NEURONS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_beat = 0;
            m_emit = 0;
            m_out  = '0;
            for (int n = 0; n < NEURONS; n++) begin
                m_acc[n] = 0;
                m_w[n]   = '0;
                m_th[n]  = IN_BITS / 2;
            end
        end else begin
            if (!m_emit) begin
                if (in_valid) begin
                    for (int n = 0; n < NEURONS; n++) begin
                        logic [CHUNK-1:0] w;
                        w = m_w[n][m_beat*CHUNK +: CHUNK];
                        m_acc[n] += CHUNK - $countones(in_data ^ w);
                    end
                    m_beat++;
                    if (m_beat == BEATS) begin
                        for (int n = 0; n < NEURONS; n++) begin
                            m_out[n] = (m_acc[n] >= m_th[n]);
                        end
                        m_beat = 0;
                        m_emit = 1;
                    end
                end
            end else if (out_ready) begin
                m_emit = 0;
                for (int n = 0; n < NEURONS; n++) m_acc[n] = 0;
            end
            if (wt_we) m_w[wt_neuron][int'(wt_beat)*CHUNK +: CHUNK] = wt_data;
            if (th_we) m_th[wt_neuron] = int'(th_data);
        end
    end

    always @(negedge clk) begin
        check("in_ready",  int'(in_ready),  int'(!m_emit));
        check("out_valid", int'(out_valid), int'(m_emit));
        check("out_data",  int'(out_data),  int'(m_out));
        check("busy",      int'(busy),      int'(m_beat != 0 || m_emit));
    end

    task automatic send_vec(input logic [IN_BITS-1:0] v);
        for (int b = 0; b < BEATS; b++) begin
            bit ok;
            int guard;
            ok = 0;
            guard = 0;
            in_valid = 1'b1;
            in_data  = v[b*CHUNK +: CHUNK];
            while (!ok) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk); #1;
                guard++;
                if (!ok && guard > 50) begin
                    check("beat_timeout", 0, 1);
                    ok = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic get_result(input logic [NEURONS-1:0] mask, input logic [NEURONS-1:0] exp,
                              input string name);
        @(negedge clk);
        check({name, "_latency"}, int'(out_valid), 1);
        check(name, int'(out_data & mask), int'(exp));
        $display("vector %s: out_data=%b mask=%b expected=%b", name, out_data, mask, exp);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic wr_w(input int n, input int b, input logic [CHUNK-1:0] d);
        wt_we = 1'b1; wt_neuron = 2'(n); wt_beat = 2'(b); wt_data = d;
        @(posedge clk); #1;
        wt_we = 1'b0;
    endtask

    task automatic wr_th(input int n, input int t);
        th_we = 1'b1; wt_neuron = 2'(n); th_data = ACC_W'(t);
        @(posedge clk); #1;
        th_we = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data),  0);
        check("rst_busy",      int'(busy),      0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Default thresholds are 8: exactly 8 matches fires, 7 does not
        send_vec(16'h00FF); get_result(4'hF, 4'b1111, "th8_exact");
        send_vec(16'h01FF); get_result(4'hF, 4'b0000, "th8_below");
        send_vec(16'h0000); get_result(4'hF, 4'b1111, "all_zero");

        wr_th(2, 0);
        send_vec(16'hFFFF); get_result(4'hF, 4'b0100, "th0_fires");
        wr_th(2, 8);

        wr_w(0, 0, 4'hA); wr_w(0, 1, 4'h5); wr_w(0, 2, 4'hA); wr_w(0, 3, 4'h5);
        wr_th(0, 12);
        send_vec(16'h0A5A); get_result(4'b0001, 4'b0001, "n0_pc14");
        send_vec(16'h000A); get_result(4'b0001, 4'b0000, "n0_pc10");
        send_vec(16'h005A); get_result(4'b0001, 4'b0001, "n0_pc12_equal");

        wr_th(3, 17);
        send_vec(16'h0000); get_result(4'b1000, 4'b0000, "th17_never");

        // Backpressure: result must hold while beats are offered
        send_vec(16'h0000);
        in_valid = 1'b1; in_data = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready",  int'(in_ready),  0);
            check("bp_out_data",  int'(out_data),  int'(4'b0110));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_resume_ready", int'(in_ready), 1);
        for (int i = 0; i < BEATS; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        get_result(4'hF, 4'b0110, "bp_next_vec");

        // Reset mid-vector
        in_valid = 1'b1; in_data = 4'hF;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_th(0, 16); wr_th(1, 15); wr_th(3, 17);
        send_vec(16'h0000); get_result(4'hF, 4'b0111, "after_reset");
        @(negedge clk);
        check("post_busy", int'(busy), 0);
        @(posedge clk); #1;

        // Randomized traffic with concurrent weight/threshold writes
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = CHUNK'($urandom);
            out_ready = ($urandom % 3) != 0;
            wt_we     = ($urandom % 6) == 0;
            wt_neuron = 2'($urandom);
            wt_beat   = 2'($urandom);
            wt_data   = CHUNK'($urandom);
            th_we     = ($urandom % 8) == 0;
            th_data   = ACC_W'($urandom_range(0, 20));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; wt_we = 1'b0; th_we = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
